cmplx_nco_mixer: RTL and testbench

//  Digital down-converter front end: mixes a real ADC sample stream with a

---
 rtl/modem_pkg.sv | 25 ++
 rtl/sincos_rom.sv | 41 ++++
 rtl/cmplx_nco_mixer.sv | 85 ++++++++
 tb/tb_cmplx_nco_mixer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/modem_pkg.sv
// Shared fixed-point constants and helpers for the modem datapath (Q1.15 samples).
package modem_pkg;

    localparam int SW = 16;
    localparam logic signed [SW-1:0] ONE    = 16'sd32767;
    localparam logic signed [SW-1:0] NEG_FS = -16'sd32768;
    localparam logic signed [2*SW-1:0] RND  = (2*SW)'(2 ** (SW - 2));

    // Round-half-up a Q2.30 product back to Q1.15 and clamp to the sample range.
    function automatic logic signed [SW-1:0] round_sat(input logic signed [2*SW-1:0] p);
        logic signed [2*SW-1:0] r;
        r = (p + RND) >>> (SW - 1);
        if (r > (2*SW)'(ONE))
            return ONE;
        if (r < (2*SW)'(NEG_FS))
            return NEG_FS;
        return r[SW-1:0];
    endfunction

    // Two's complement negate where -full-scale has no positive counterpart.
    function automatic logic signed [SW-1:0] neg_sat(input logic signed [SW-1:0] s);
        return (s == NEG_FS) ? ONE : -s;
    endfunction

endpackage

// File: rtl/sincos_rom.sv
// Quarter-free full-turn cos/sin table with a registered, enabled read port.
module sincos_rom #(
    parameter int LW = 8,
    parameter int W  = 16
) (
    input  logic            clk,
    input  logic            en,
    input  logic [LW-1:0]   addr,
    output logic [2*W-1:0]  data
);

    localparam int DEPTH = 2 ** LW;

    function automatic logic [W-1:0] to_q(input real v);
        real s;
        int  r;
        s = v * real'((2 ** (W - 1)) - 1);
        r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
        return W'(r);
    endfunction

    // Entry i = {cos, sin} of 2*pi*i/DEPTH, built at elaboration time.
    function automatic logic [DEPTH*2*W-1:0] build_table();
        logic [DEPTH*2*W-1:0] t;
        real a;
        t = '0;
        for (int i = 0; i < DEPTH; i++) begin
            a = 6.283185307179586 * real'(i) / real'(DEPTH);
            t[i*2*W +: 2*W] = {to_q($cos(a)), to_q($sin(a))};
        end
        return t;
    endfunction

    localparam logic [DEPTH*2*W-1:0] TABLE = build_table();

    always_ff @(posedge clk) begin
        if (en)
            data <= TABLE[32'(addr) * (2*W) +: 2*W];
    end

endmodule

// File: rtl/cmplx_nco_mixer.sv
// Real-to-complex mixer: x * (cos, -sin) of an NCO phase, 3-stage valid/ready pipeline.
module cmplx_nco_mixer
    import modem_pkg::*;
#(
    parameter int W  = SW,
    parameter int PW = 32,
    parameter int LW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PW-1:0]       phase_inc_i,
    input  logic                phase_we_i,
    input  logic signed [W-1:0] x_i,
    input  logic                x_valid_i,
    output logic                x_ready_o,
    output logic signed [W-1:0] y_a_o,
    output logic signed [W-1:0] y_b_o,
    output logic                y_valid_o,
    input  logic                y_ready_i
);

    logic                en;
    logic                accept;
    logic [PW-1:0]       phase;
    logic [PW-1:0]       inc;
    logic [2:0]          vld_pipe;
    logic signed [W-1:0] x0;
    logic signed [W-1:0] x1;
    logic [LW-1:0]       idx0;
    logic [2*W-1:0]      cs1;
    logic signed [W-1:0] cos1;
    logic signed [W-1:0] nsin1;
    logic signed [2*W-1:0] p_a;
    logic signed [2*W-1:0] p_b;

    // Whole pipeline stalls as one unit: only the output register can block.
    assign en        = !y_valid_o || y_ready_i;
    assign x_ready_o = en;
    assign accept    = x_valid_i && en;
    assign y_valid_o = vld_pipe[2];

    sincos_rom #(.LW(LW), .W(W)) u_rom (
        .clk  (clk),
        .en   (en),
        .addr (idx0),
        .data (cs1)
    );

    assign cos1  = cs1[2*W-1:W];
    assign nsin1 = neg_sat(cs1[W-1:0]);
    assign p_a   = (2*W)'(x1) * (2*W)'(cos1);
    assign p_b   = (2*W)'(x1) * (2*W)'(nsin1);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            inc      <= '0;
            vld_pipe <= '0;
            y_a_o    <= '0;
            y_b_o    <= '0;
        end else begin
            if (phase_we_i)
                inc <= phase_inc_i;
            if (en) begin
                // Uses the increment in force before any same-cycle load.
                if (accept)
                    phase <= phase + inc;
                vld_pipe <= {vld_pipe[1:0], accept};
                if (vld_pipe[1]) begin
                    y_a_o <= round_sat(p_a);
                    y_b_o <= round_sat(p_b);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            x0   <= x_i;
            idx0 <= phase[PW-1 -: LW];
            x1   <= x0;
        end
    end

endmodule

// File: tb/tb_cmplx_nco_mixer.sv
// Directed + randomized bench for cmplx_nco_mixer against a queue-based NCO/mixer model.
module tb_cmplx_nco_mixer;

    logic               clk = 0;
    logic               rst;
    logic [31:0]        phase_inc;
    logic               phase_we;
    logic signed [15:0] x;
    logic               x_valid;
    logic               x_ready;
    logic signed [15:0] y_a;
    logic signed [15:0] y_b;
    logic               y_valid;
    logic               y_ready;

    int n_assert = 0;
    int n_fail   = 0;

    int          tc [256];
    int          ts [256];
    logic [31:0] mphase, minc;
    logic [31:0] q[$];
    logic [31:0] obs[$];
    logic        hold_vld;
    logic [31:0] hold_val;

    always #5 clk = ~clk;

    cmplx_nco_mixer dut (
        .clk         (clk),
        .rst         (rst),
        .phase_inc_i (phase_inc),
        .phase_we_i  (phase_we),
        .x_i         (x),
        .x_valid_i   (x_valid),
        .x_ready_o   (x_ready),
        .y_a_o       (y_a),
        .y_b_o       (y_b),
        .y_valid_o   (y_valid),
        .y_ready_i   (y_ready)
    );

    task automatic chk(input string tag, input logic signed [63:0] o, input logic signed [63:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic int toq(input real v);
        real s;
        s = v * 32767.0;
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    endfunction

    function automatic logic signed [15:0] rsat(input longint p);
        longint r;
        r = (p + 16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    // I = x*cos(phi), Q = x*(-sin(phi)) with Q1.15 rounding and saturation.
    function automatic logic [31:0] mix(input int xv, input int idx);
        int ns;
        ns = (ts[idx] == -32768) ? 32767 : -ts[idx];
        return {rsat(longint'(xv) * tc[idx]), rsat(longint'(xv) * ns)};
    endfunction

    // One clock: observe at the falling edge, then leave time just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            q.delete();
            obs.delete();
            mphase   = 0;
            minc     = 0;
            hold_vld = 0;
        end else begin
            if (hold_vld) begin
                chk("hold_valid", y_valid, 1);
                chk("hold_data", {y_a, y_b}, hold_val);
            end
            chk("x_ready", x_ready, !y_valid || y_ready);
            if (y_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("y_pair", {y_a, y_b}, q[0]);
                    if (y_ready) begin
                        void'(q.pop_front());
                        obs.push_back({y_a, y_b});
                    end
                end
            end
            hold_vld = y_valid && !y_ready;
            hold_val = {y_a, y_b};
            if (x_valid && x_ready) begin
                q.push_back(mix(int'(x), int'(mphase[31:24])));
                mphase = mphase + minc;
            end
            if (phase_we)
                minc = phase_inc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        x_valid  = 0;
        phase_we = 0;
        y_ready  = 1;
        n = 0;
        while ((q.size() != 0 || y_valid) && n < 30) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 30, 1);
    endtask

    task automatic chk_obs(input string tag, input int i, input int ei, input int eq);
        if (i >= obs.size()) begin
            chk({tag, "_missing"}, obs.size(), i + 1);
        end else begin
            chk({tag, "_I"}, $signed(obs[i][31:16]), ei);
            chk({tag, "_Q"}, $signed(obs[i][15:0]), eq);
        end
    endtask

    initial begin
        int lat;
        int t2_i [4];
        int t2_q [4];
        t2_i = '{16384, 0, -16383, 0};
        t2_q = '{0, -16383, 0, 16384};
        for (int i = 0; i < 256; i++) begin
            tc[i] = toq($cos(6.283185307179586 * real'(i) / 256.0));
            ts[i] = toq($sin(6.283185307179586 * real'(i) / 256.0));
        end
        rst = 1; phase_inc = 0; phase_we = 0; x = 0; x_valid = 0; y_ready = 1;
        mphase = 0; minc = 0; hold_vld = 0; hold_val = 0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_a", y_a, 0);
        chk("rst_y_b", y_b, 0);
        tick();
        rst = 0;

        // 1: inc=0, constant x, latency and steady output
        x_valid = 1; x = 16384;
        tick();
        lat = 1;
        while (!y_valid && lat < 10) begin tick(); lat++; end
        chk("t1_latency", lat, 3);
        repeat (6) tick();
        chk("t1_I", y_a, 16384);
        chk("t1_Q", y_b, 0);
        drain();

        // 2: quarter-turn increment
        phase_we = 1; phase_inc = 32'h4000_0000; tick(); phase_we = 0;
        obs.delete();
        x_valid = 1; x = 16384;
        repeat (8) tick();
        drain();
        chk("t2_count", obs.size(), 8);
        for (int i = 0; i < 8; i++) chk_obs("t2", i, t2_i[i % 4], t2_q[i % 4]);

        // 3: negative quarter-turn (wrap), full-scale negative input at idx 0
        phase_we = 1; phase_inc = 32'hC000_0000; tick(); phase_we = 0;
        obs.delete();
        x_valid = 1; x = -16'sd32768; tick();
        x = 16384; repeat (3) tick();
        drain();
        chk_obs("t3_idx0", 0, -32767, 0);
        chk_obs("t3_idx192", 1, 0, 16384);
        chk_obs("t3_idx128", 2, -16383, 0);
        chk_obs("t3_idx64", 3, 0, -16383);

        // 4: backpressure hold for 5 cycles mid-stream
        phase_we = 1; phase_inc = $urandom; tick(); phase_we = 0;
        x_valid = 1;
        repeat (6) begin x = 16'($urandom); tick(); end
        y_ready = 0;
        repeat (5) begin x = 16'($urandom); tick(); end
        chk("t4_stall_ready", x_ready, 0);
        chk("t4_stall_valid", y_valid, 1);
        y_ready = 1;
        repeat (6) begin x = 16'($urandom); tick(); end
        drain();

        // 5: increment load coincident with an accept
        rst = 1; tick(); rst = 0;
        x_valid = 1; x = 16384; phase_we = 1; phase_inc = 32'h4000_0000;
        tick();
        phase_we = 0;
        repeat (2) tick();
        drain();
        chk_obs("t5_k", 0, 16384, 0);
        chk_obs("t5_k1", 1, 16384, 0);
        chk_obs("t5_k2", 2, 0, -16383);

        // 6: reset with samples in flight
        x_valid = 1; x = 12000;
        repeat (4) tick();
        rst = 1; tick(); rst = 0;
        chk("t6_valid_after_rst", y_valid, 0);
        x_valid = 1; x = 16384;
        repeat (4) tick();
        drain();
        chk("t6_count", obs.size(), 4);
        for (int i = 0; i < 4; i++) chk_obs("t6", i, 16384, 0);

        // Random traffic, backpressure and increment reloads
        for (int i = 0; i < 300; i++) begin
            x_valid   = ($urandom_range(0, 3) != 0);
            y_ready   = ($urandom_range(0, 3) != 0);
            x         = 16'($urandom);
            phase_we  = ($urandom_range(0, 19) == 0);
            phase_inc = $urandom;
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
